// File: rtl/cordic_pkg.sv
// Constants and helpers shared by the CORDIC angle stage and the blocks downstream of it.
// Angles are signed two's complement, with pi mapped to round(pi * 2^(width-3)).
package cordic_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // pi * 2^29, rounded; rescaled below to any angle width from 3 to 32
    localparam logic [63:0] C_PI_Q29 = 64'd1686629713;

    function automatic int F_pi_const(input int width);
        logic [63:0] r;
        r = (C_PI_Q29 + (64'd1 << (31 - width))) >> (32 - width);
        return int'(r);
    endfunction

    function automatic int F_two_pi_const(input int width);
        return 2 * F_pi_const(width);
    endfunction

    // Internal CORDIC datapath width: the angle width plus guard bits
    function automatic int F_cal_width(input int width);
        return width + $clog2(width) + 2;
    endfunction

endpackage

// File: rtl/cordic_freq_est_if.sv
// Angle-sample in / frequency-result out bundle for cordic_freq_est.
// Strobe semantics: there is no ready. A sample is taken in every cycle in which I_angle_v is high.
// Each O_*_v output is a one-cycle pulse that qualifies its data, and the data holds between pulses.
interface cordic_freq_est_if #(parameter int W = 16);
    logic signed [W-1:0] I_angle;
    logic                I_angle_v;
    logic                I_clr;
    logic signed [W-1:0] O_dphase;
    logic                O_dphase_v;
    logic signed [W-1:0] O_freq;
    logic                O_freq_v;

    modport master (
        output I_angle, I_angle_v, I_clr,
        input  O_dphase, O_dphase_v, O_freq, O_freq_v
    );
    modport slave (
        input  I_angle, I_angle_v, I_clr,
        output O_dphase, O_dphase_v, O_freq, O_freq_v
    );
endinterface

// File: rtl/angle_diff_wrap.sv
// Two-stage registered angle difference I_a - I_b, wrapped into (-pi, pi].
// I_flush drops any difference in flight and does not touch the data registers.
module angle_diff_wrap
    import cordic_pkg::*;
#(
    parameter int C_ANGLE_WIDTH = 16
) (
    input  logic                            I_clk,
    input  logic                            I_rst,
    input  logic                            I_flush,
    input  logic signed [C_ANGLE_WIDTH-1:0] I_a,
    input  logic signed [C_ANGLE_WIDTH-1:0] I_b,
    input  logic                            I_v,
    output logic signed [C_ANGLE_WIDTH-1:0] O_d,
    output logic                            O_d_v
);
    localparam int W        = C_ANGLE_WIDTH;
    localparam int PI_I     = F_pi_const(W);
    localparam int TWO_PI_I = F_two_pi_const(W);
    localparam logic signed [W:0] PI     = PI_I[W:0];
    localparam logic signed [W:0] NEG_PI = -PI;
    localparam logic [W-1:0]      TWO_PI_W = TWO_PI_I[W-1:0];

    logic signed [W:0]   raw_q;
    logic                raw_v_q;
    logic signed [W-1:0] wrap;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            raw_q   <= '0;
            raw_v_q <= 1'b0;
        end else begin
            raw_v_q <= I_v & ~I_flush;
            if (I_v)
                raw_q <= {I_a[W-1], I_a} - {I_b[W-1], I_b};
        end
    end

    // The corrected result always fits W bits, so modulo-2^W low-bit arithmetic is exact
    always_comb begin
        wrap = raw_q[W-1:0];
        if (raw_q > PI)
            wrap = raw_q[W-1:0] - TWO_PI_W;
        else if (raw_q <= NEG_PI)
            wrap = raw_q[W-1:0] + TWO_PI_W;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_d   <= '0;
            O_d_v <= 1'b0;
        end else begin
            O_d_v <= raw_v_q & ~I_flush;
            if (raw_v_q & ~I_flush)
                O_d <= wrap;
        end
    end
endmodule

// File: rtl/cordic_freq_est.sv
// Phase-differencing frequency estimator: wrapped per-sample increment plus the
// average of each block of 2^C_AVG_LOG2 increments.
module cordic_freq_est
    import cordic_pkg::*;
#(
    parameter int C_ANGLE_WIDTH = 16,
    parameter int C_AVG_LOG2    = 4
) (
    input  logic               I_clk,
    input  logic               I_rst,
    cordic_freq_est_if.slave   bus,
    output state_e             O_state
);
    localparam int W     = C_ANGLE_WIDTH;
    localparam int ACC_W = W + C_AVG_LOG2;

    state_e                  state_q, state_d;
    logic signed [W-1:0]     ref_q;
    logic                    diff_v;
    logic signed [W-1:0]     dphase;
    logic                    dphase_v;
    logic signed [ACC_W-1:0] acc_q, acc_sum;
    logic [C_AVG_LOG2-1:0]   cnt_q;
    logic signed [W-1:0]     freq_q;
    logic                    freq_v_q;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // A sample that arrives together with a clear still becomes the new reference
    always_comb begin
        state_d = state_q;
        if (bus.I_angle_v)  state_d = ST_RUN;
        else if (bus.I_clr) state_d = ST_EMPTY;
    end

    always_comb begin
        diff_v  = bus.I_angle_v & ~bus.I_clr & (state_q == ST_RUN);
        O_state = state_q;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)               ref_q <= '0;
        else if (bus.I_angle_v)  ref_q <= bus.I_angle;
        else if (bus.I_clr)      ref_q <= '0;
    end

    angle_diff_wrap #(.C_ANGLE_WIDTH(W)) u_diff (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_flush (bus.I_clr),
        .I_a     (bus.I_angle),
        .I_b     (ref_q),
        .I_v     (diff_v),
        .O_d     (dphase),
        .O_d_v   (dphase_v)
    );

    assign acc_sum = acc_q + {{C_AVG_LOG2{dphase[W-1]}}, dphase};

    // Taking the upper W bits of the block sum is the arithmetic shift right by C_AVG_LOG2
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            freq_q   <= '0;
            freq_v_q <= 1'b0;
        end else begin
            freq_v_q <= 1'b0;
            if (bus.I_clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (dphase_v) begin
                if (&cnt_q) begin
                    freq_q   <= acc_sum[ACC_W-1:C_AVG_LOG2];
                    freq_v_q <= 1'b1;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + C_AVG_LOG2'(1);
                end
            end
        end
    end

    assign bus.O_dphase   = dphase;
    assign bus.O_dphase_v = dphase_v;
    assign bus.O_freq     = freq_q;
    assign bus.O_freq_v   = freq_v_q;
endmodule

// File: tb/tb_cordic_freq_est.sv
// Directed bench for cordic_freq_est with W=16 and blocks of four increments.
module tb_cordic_freq_est;
    import cordic_pkg::*;

    localparam int W   = 16;
    localparam int AVG = 2;

    logic   I_clk = 1'b0;
    logic   I_rst;
    state_e dbg_state;
    int     n_cmp = 0;
    int     n_err = 0;

    cordic_freq_est_if #(.W(W)) bus ();

    cordic_freq_est #(.C_ANGLE_WIDTH(W), .C_AVG_LOG2(AVG)) dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .bus     (bus),
        .O_state (dbg_state)
    );

    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input logic c);
        bus.I_angle_v = v;
        bus.I_angle   = 16'(a);
        bus.I_clr     = c;
    endtask

    task automatic clear();
        drive(1'b0, 0, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0);
    endtask

    // Five back-to-back samples with constant step: four increments, then one block average
    task automatic ramp(input string tag, input int start, input int step);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, start + k * step, 1'b0);
            tick();
            chk({tag, "_dv"}, 32'(bus.O_dphase_v), (k >= 2) ? 1 : 0);
            if (k >= 2) chk({tag, "_d"}, 32'($signed(bus.O_dphase)), step);
            chk({tag, "_fv_idle"}, 32'(bus.O_freq_v), 0);
        end
        drive(1'b0, 0, 1'b0);
        tick();
        chk({tag, "_dv_last"}, 32'(bus.O_dphase_v), 1);
        chk({tag, "_d_last"}, 32'($signed(bus.O_dphase)), step);
        chk({tag, "_fv_early"}, 32'(bus.O_freq_v), 0);
        tick();
        chk({tag, "_fv"}, 32'(bus.O_freq_v), 1);
        chk({tag, "_f"}, 32'($signed(bus.O_freq)), step);
        chk({tag, "_dv_after"}, 32'(bus.O_dphase_v), 0);
        tick();
        chk({tag, "_fv_after"}, 32'(bus.O_freq_v), 0);
    endtask

    task automatic wrap_pair(input string tag, input int a, input int b, input int exp);
        clear();
        drive(1'b1, a, 1'b0);
        tick();
        drive(1'b1, b, 1'b0);
        tick();
        drive(1'b0, 0, 1'b0);
        chk({tag, "_dv_early"}, 32'(bus.O_dphase_v), 0);
        tick();
        chk({tag, "_dv"}, 32'(bus.O_dphase_v), 1);
        chk({tag, "_d"}, 32'($signed(bus.O_dphase)), exp);
        tick();
        chk({tag, "_dv_after"}, 32'(bus.O_dphase_v), 0);
    endtask

    initial begin
        int neg[5];
        neg = '{0, -1, -2, -3, -5};
        drive(1'b0, 0, 1'b0);
        I_rst = 1'b1;
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_dphase", 32'($signed(bus.O_dphase)), 0);
        chk("rst_dphase_v", 32'(bus.O_dphase_v), 0);
        chk("rst_freq", 32'($signed(bus.O_freq)), 0);
        chk("rst_freq_v", 32'(bus.O_freq_v), 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
        I_rst = 1'b0;
        tick();

        // Linear ramp
        ramp("ramp", 0, 1000);

        // Wrap corrections at and around +/-pi
        wrap_pair("wrap_pos", 25000, -25000, 1472);
        wrap_pair("wrap_neg", -25000, 25000, -1472);
        wrap_pair("wrap_pi", 0, 25736, 25736);
        wrap_pair("wrap_mpi", 25736, 0, 25736);

        // Negative block sum truncates toward -inf: -5 >>> 2 = -2
        clear();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, neg[k], 1'b0);
            tick();
        end
        drive(1'b0, 0, 1'b0);
        tick();
        chk("neg_d", 32'($signed(bus.O_dphase)), -2);
        tick();
        chk("neg_fv", 32'(bus.O_freq_v), 1);
        chk("neg_f", 32'($signed(bus.O_freq)), -2);

        // Clear mid-block, with the clearing sample becoming the new reference
        clear();
        drive(1'b1, 6000, 1'b0); tick();
        drive(1'b1, 6500, 1'b0); tick();
        drive(1'b1, 7000, 1'b0); tick();
        chk("clr_pre_dv", 32'(bus.O_dphase_v), 1);
        chk("clr_pre_d", 32'($signed(bus.O_dphase)), 500);
        drive(1'b1, 7000, 1'b1); tick();
        chk("clr_suppress_dv", 32'(bus.O_dphase_v), 0);
        chk("clr_state", 32'(dbg_state), 32'(ST_RUN));
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 7100 + 100 * k, 1'b0);
            tick();
            chk("clr_dv", 32'(bus.O_dphase_v), (k >= 1) ? 1 : 0);
            if (k >= 1) chk("clr_d", 32'($signed(bus.O_dphase)), 100);
            chk("clr_fv_idle", 32'(bus.O_freq_v), 0);
        end
        drive(1'b0, 0, 1'b0);
        tick();
        chk("clr_dv_last", 32'(bus.O_dphase_v), 1);
        chk("clr_d_last", 32'($signed(bus.O_dphase)), 100);
        chk("clr_fv_early", 32'(bus.O_freq_v), 0);
        tick();
        chk("clr_fv", 32'(bus.O_freq_v), 1);
        chk("clr_f", 32'($signed(bus.O_freq)), 100);
        tick();

        // Gapped samples: an idle stretch does not age the reference
        clear();
        drive(1'b1, 0, 1'b0); tick();
        drive(1'b0, 0, 1'b0);
        repeat (50) tick();
        drive(1'b1, 300, 1'b0); tick();
        drive(1'b0, 0, 1'b0);
        chk("gap_dv_early", 32'(bus.O_dphase_v), 0);
        tick();
        chk("gap_dv", 32'(bus.O_dphase_v), 1);
        chk("gap_d", 32'($signed(bus.O_dphase)), 300);

        // Asynchronous reset in the middle of a block
        clear();
        drive(1'b1, 100, 1'b0); tick();
        drive(1'b1, 200, 1'b0); tick();
        drive(1'b1, 300, 1'b0); tick();
        drive(1'b0, 0, 1'b0);
        tick();
        chk("arst_pre_d", 32'($signed(bus.O_dphase)), 100);
        #3;
        I_rst = 1'b1;
        #1;
        chk("arst_dphase", 32'($signed(bus.O_dphase)), 0);
        chk("arst_dphase_v", 32'(bus.O_dphase_v), 0);
        chk("arst_freq", 32'($signed(bus.O_freq)), 0);
        chk("arst_freq_v", 32'(bus.O_freq_v), 0);
        chk("arst_state", 32'(dbg_state), 32'(ST_EMPTY));
        tick();
        tick();
        I_rst = 1'b0;
        tick();
        ramp("post_rst", 5000, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
